// File: rtl/db_defs.sv
// rtl/db_defs.sv - shared state encodings and width helpers for the debounce one-shot
package db_defs;

  typedef enum logic [2:0] {
    ST_LOW   = 3'd0,
    ST_RISE  = 3'd1,
    ST_PULSE = 3'd2,
    ST_HIGH  = 3'd3,
    ST_FALL  = 3'd4
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchronizer with synchronous clear
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (clr) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/db_1shot_pulse.sv
// rtl/db_1shot_pulse.sv - button debounce with one-shot press pulse; DB_REPEAT_EN adds auto-repeat
module db_1shot_pulse
  import db_defs::*;
#(
  parameter int DB_CYCLES  = 4,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 10
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_in,
  output logic pulse_out,
  output logic level_out
);

  localparam int CNT_W = cnt_w(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || REPEAT_DLY < 2 || REPEAT_PER < 2) begin : g_bad_param
    $error("db_1shot_pulse: DB_CYCLES, REPEAT_DLY and REPEAT_PER must be >= 2");
  end

  logic             btn_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rep_fire;

  sync_2ff u_sync (
    .clk (clk),
    .clr (clr),
    .d   (btn_in),
    .q   (btn_s)
  );

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_LOW;
      cnt       <= '0;
      pulse_out <= 1'b0;
      level_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pulse_out <= (state_nxt == ST_PULSE) || rep_fire;
      level_out <= (state_nxt == ST_PULSE) || (state_nxt == ST_HIGH) || (state_nxt == ST_FALL);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      ST_LOW: begin
        if (btn_s) begin
          state_nxt = ST_RISE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_RISE: begin
        if (!btn_s)               state_nxt = ST_LOW;
        else if (cnt == CNT_LAST) state_nxt = ST_PULSE;
        else                      cnt_nxt   = cnt + 1'b1;
      end
      ST_PULSE: state_nxt = ST_HIGH;
      ST_HIGH: begin
        if (!btn_s) begin
          state_nxt = ST_FALL;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_FALL: begin
        if (btn_s)                state_nxt = ST_HIGH;
        else if (cnt == CNT_LAST) state_nxt = ST_LOW;
        else                      cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = ST_LOW;
    endcase
  end

`ifdef DB_REPEAT_EN
  localparam int REP_W = cnt_w(max2(REPEAT_DLY, REPEAT_PER));

  logic [REP_W-1:0] rcnt;
  logic             rep_first;
  logic [REP_W-1:0] rep_lim;

  // The first gap is counted from the cycle after ST_PULSE, hence DLY-2 against PER-1.
  assign rep_lim  = rep_first ? REP_W'(REPEAT_DLY - 2) : REP_W'(REPEAT_PER - 1);
  assign rep_fire = (state == ST_HIGH) && btn_s && (rcnt == rep_lim);

  always_ff @(posedge clk) begin
    if (clr || state != ST_HIGH) begin
      rcnt      <= '0;
      rep_first <= 1'b1;
    end else if (rep_fire) begin
      rcnt      <= '0;
      rep_first <= 1'b0;
    end else if (btn_s) begin
      rcnt      <= rcnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_db_1shot_pulse.sv
// tb/tb_db_1shot_pulse.sv - self-checking bench for db_1shot_pulse against a run-length model
module tb_db_1shot_pulse;

  localparam int DB  = 4;
  localparam int DLY = 50;
  localparam int PER = 10;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic btn_in = 1'b0;
  logic pulse_out;
  logic level_out;

  always #5 clk = ~clk;

  db_1shot_pulse #(.DB_CYCLES(DB), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
    .clk       (clk),
    .clr       (clr),
    .btn_in    (btn_in),
    .pulse_out (pulse_out),
    .level_out (level_out)
  );

  int errors = 0;
  int checks = 0;
  int ecnt = 0;
  int npulse = 0;
  int last_pulse_e = -1;
  int last_fall_e = -1;

  // Reference: level flips once DB consecutive synchronized samples disagree with it;
  // the sample taken in the pulse cycle is ignored.
  bit h1 = 0, h2 = 0, m_lvl = 0, m_pulse = 0, m_skip = 0, m_first = 0;
  int m_run = 0, m_t = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit c, input bit b);
    bit s;
    if (c) begin
      h1 = 0; h2 = 0; m_lvl = 0; m_pulse = 0; m_skip = 0; m_run = 0; m_t = 0; m_first = 0;
      return;
    end
    s = h2;
    h2 = h1;
    h1 = b;
    m_pulse = 0;
    if (m_skip) begin
      m_skip = 0;
      m_t++;
    end else if (s != m_lvl) begin
      m_run++;
      if (m_run == DB) begin
        m_lvl = s;
        m_run = 0;
        if (s) begin
          m_pulse = 1; m_skip = 1; m_t = 0; m_first = 1;
        end
      end
    end else begin
      if (m_lvl && m_run > 0) begin
        m_t = 1; m_first = 1;
      end else if (m_lvl) begin
        m_t++;
`ifdef DB_REPEAT_EN
        if (m_t == (m_first ? DLY : PER)) begin
          m_pulse = 1; m_t = 0; m_first = 0;
        end
`endif
      end
      m_run = 0;
    end
  endtask

  bit prev_lvl = 0;
  initial begin
    forever begin
      @(posedge clk);
      model_step(clr, btn_in);
      ecnt++;
      #1;
      check("pulse_model", int'(pulse_out), int'(m_pulse));
      check("level_model", int'(level_out), int'(m_lvl));
      if (pulse_out && !level_out) check("pulse_without_level", 1, 0);
      if (pulse_out) begin
        npulse++;
        last_pulse_e = ecnt;
      end
      if (prev_lvl && !level_out) last_fall_e = ecnt;
      prev_lvl = level_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int base, p0;
  initial begin
    clr = 1'b1;
    btn_in = 1'b0;
    tick(2);
    check("reset_pulse", int'(pulse_out), 0);
    check("reset_level", int'(level_out), 0);

    clr = 1'b0;
    btn_in = 1'b1;
    base = ecnt;
    p0 = npulse;
    tick(12);
    check("press_latency", last_pulse_e - base, 6);
    check("press_count", npulse - p0, 1);
    check("press_level", int'(level_out), 1);

    btn_in = 1'b0;
    tick(12);
    p0 = npulse;
    for (int i = 0; i < 6; i++) begin
      btn_in = (i == 2 || i == 5) ? 1'b0 : 1'b1;
      tick(1);
    end
    btn_in = 1'b0;
    tick(10);
    check("bounce_count", npulse - p0, 0);
    check("bounce_level", int'(level_out), 0);

    btn_in = 1'b1;
    tick(15);
    p0 = npulse;
    btn_in = 1'b0; tick(1);
    btn_in = 1'b0; tick(1);
    btn_in = 1'b1; tick(1);
    btn_in = 1'b0;
    base = ecnt;
    tick(12);
    check("release_latency", last_fall_e - base, 6);
    check("release_count", npulse - p0, 0);

    p0 = npulse;
    btn_in = 1'b1;
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    base = ecnt;
    tick(12);
    check("clr_mid_latency", last_pulse_e - base, 6);
    check("clr_mid_count", npulse - p0, 1);

    btn_in = 1'b0;
    tick(20);
    p0 = npulse;
    repeat (3) begin
      btn_in = 1'b1; tick(10);
      btn_in = 1'b0; tick(20);
    end
    check("three_presses", npulse - p0, 3);

    p0 = npulse;
    btn_in = 1'b1;
    tick(105);
`ifdef DB_REPEAT_EN
    check("hold_pulses", npulse - p0, 6);
`else
    check("hold_pulses", npulse - p0, 1);
`endif
    btn_in = 1'b0;
    tick(12);

    p0 = npulse;
    for (int i = 0; i < 40; i++) begin
      btn_in = ~btn_in;
      tick(1);
    end
    btn_in = 1'b0;
    tick(4);
    check("toggle_count", npulse - p0, 0);
    check("toggle_level", int'(level_out), 0);

    for (int seg = 0; seg < 300; seg++) begin
      btn_in = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 19) == 0);
      tick(1);
      clr = 1'b0;
      tick($urandom_range(0, 11));
    end
    btn_in = 1'b0;
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/db_1shot_pulse.md
Name: db_1shot_pulse

Overview:
- Debounce and one-shot stage upstream of the loadable up counter.
- Takes a raw asynchronous button/switch level and synchronizes it, then debounces it.
- Emits a single-cycle pulse per qualified press, which drives the counter's up input.
- Also exports the clean debounced level for LEDs or other logic.

Parameters:
- DB_CYCLES, 4, number of consecutive synchronized-high (or -low) samples needed to qualify an edge; must be >= 2.
- REPEAT_DLY, 50, cycles held high before the first auto-repeat pulse; used only with DB_REPEAT_EN.
- REPEAT_PER, 10, cycles between subsequent auto-repeat pulses; used only with DB_REPEAT_EN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, synchronous, active-high; highest priority.
- btn_in  input  1  raw asynchronous button level.
- pulse_out  output  1  one-clk-wide registered pulse per qualified press; connects to the counter's up input.
- level_out  output  1  debounced level, registered.

Behaviour:
- Reset:
  - clr=1 at a rising edge forces state ST_LOW and clears the debounce counter, both synchronizer flops, pulse_out and level_out.
  - clr overrides all other activity, including mid-debounce or mid-pulse.
- Synchronizer: two flops, btn_in -> s1 -> btn_s. There is no logic between the flops.
- Debounce counter: cnt, width CNT_W = $clog2(DB_CYCLES+1). It clears on every state change and never wraps.
- FSM, Moore outputs:
  - ST_LOW: level_out=0.
    - btn_s=1 -> ST_RISE, cnt=1.
  - ST_RISE: level_out=0.
    - btn_s=0 -> ST_LOW (bounce rejected, no pulse).
    - btn_s=1 and cnt==DB_CYCLES-1 -> ST_PULSE.
    - Otherwise cnt+1.
  - ST_PULSE: pulse_out=1, level_out=1. Unconditionally -> ST_HIGH.
  - ST_HIGH: level_out=1.
    - btn_s=0 -> ST_FALL, cnt=1.
  - ST_FALL: level_out=1.
    - btn_s=1 -> ST_HIGH (release bounce rejected).
    - btn_s=0 and cnt==DB_CYCLES-1 -> ST_LOW.
    - Otherwise cnt+1.
- Latency:
  - With btn_in stable high from edge 1 onward, pulse_out is high only in the cycle after edge DB_CYCLES+2.
  - level_out rises in that same cycle.
  - Release latency to level_out=0 is likewise DB_CYCLES+2 edges.
- pulse_out:
  - Exactly one cycle wide per press.
  - Never asserted in two consecutive cycles.
  - Never asserted while level_out=0.
- Holding the button indefinitely produces no further pulses unless DB_REPEAT_EN is defined.
- Releases never produce pulses.
- btn_in toggling every cycle forever produces no pulse and level_out stays 0.
- All outputs are registered. There is no combinational path from btn_in or clr to any output.

Optional Feature:
- Macro: DB_REPEAT_EN.
- Defined:
  - ST_HIGH runs a repeat counter, width $clog2(max(REPEAT_DLY,REPEAT_PER)+1), cleared on entry to ST_HIGH.
  - pulse_out asserts for one cycle REPEAT_DLY cycles after ST_PULSE, then every REPEAT_PER cycles while btn_s stays 1.
  - Entering ST_FALL clears the repeat counter.
  - Returning ST_FALL->ST_HIGH restarts the counter, with REPEAT_DLY applied again.
- Undefined: no repeat counter is synthesized; behaviour is exactly as above.
- Port list is identical in both builds.

Decomposition:
- Shared package/header db_defs holds:
  - state encodings ST_LOW=3'd0, ST_RISE=3'd1, ST_PULSE=3'd2, ST_HIGH=3'd3, ST_FALL=3'd4;
  - the CNT_W width function.
- One natural sub-module: sync_2ff, a single-bit two-flop synchronizer with clk and clr. It is reusable for switch inputs elsewhere in the MCU.

Test Plan:
- DB_CYCLES=4. clr=1 for 2 cycles, then btn_in=1 stable -> pulse_out=1 for exactly one cycle after edge 6; level_out=1 from that cycle on. Counter downstream reads count=1.
- btn_in pattern 1,1,0,1,1,0 (bounce shorter than 4 samples) -> pulse_out stays 0, level_out stays 0.
- After a qualified press, release with bounce 0,0,1,0 then stable 0 -> no pulse; level_out falls 6 edges after the final 0 begins.
- btn_in=1 stable, clr=1 asserted at edge 4 (mid ST_RISE) -> state ST_LOW, no pulse. Re-qualification then needs the full 6 edges after clr deasserts.
- Three clean presses separated by 20 low cycles -> exactly 3 pulses; downstream cntr count=3.
- DB_REPEAT_EN defined, REPEAT_DLY=50, REPEAT_PER=10, hold 100 cycles after first pulse -> pulses at +0, +50, +60, +70, +80, +90 relative to the first pulse. Undefined build -> only +0.
